// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: request/result bundle between the EX stage and the
// multiply/divide sequencer. The EX side is the master; the MDU is the slave.
interface mdu_ctrl_if;
  logic        req_valid;
  logic [2:0]  func;
  logic        is_sign;
  logic [31:0] a;
  logic [31:0] b;
  logic        mf_req;
  logic        flush;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;

  modport master (
    output req_valid, func, is_sign, a, b, mf_req, flush,
    input  hi, lo, busy, stall
  );

  modport slave (
    input  req_valid, func, is_sign, a, b, mf_req, flush,
    output hi, lo, busy, stall
  );
endinterface

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: EX-stage multiply/divide sequencer owning the HI/LO registers.
// MULT completes after MUL_LAT cycles; DIV is a 32-step restoring divider
// followed by a one-cycle sign fix-up. MTHI/MTLO complete immediately.
// Define MDU_DIV_EN to build the divider; without it DIV is a one-cycle no-op.
module mdu_ctrl #(
  parameter int MUL_LAT = 3
) (
  input  logic       clk,
  input  logic       rst,
  mdu_ctrl_if.slave  bus
);

  localparam logic [2:0] F_MULT = 3'd1;
  localparam logic [2:0] F_DIV  = 3'd2;
  localparam logic [2:0] F_MTHI = 3'd3;
  localparam logic [2:0] F_MTLO = 3'd4;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t      state_reg, state_next;
  logic [4:0]  cnt_reg, cnt_next;
  logic [31:0] hi_reg, hi_next;
  logic [31:0] lo_reg, lo_next;
  // MULT: both operands. DIV: opa keeps raw a (divide-by-zero HI), opb the divisor magnitude.
  logic [31:0] opa_reg, opa_next;
  logic [31:0] opb_reg, opb_next;
  logic        sign_reg, sign_next;

  logic [63:0] mul_ext_a, mul_ext_b, product;

`ifdef MDU_DIV_EN
  logic [31:0] quo_reg, quo_next;   // dividend shifts out the top, quotient bits shift in
  logic [31:0] rem_reg, rem_next;
  logic        qneg_reg, qneg_next;
  logic        rneg_reg, rneg_next;
  logic        dzero_reg, dzero_next;
  logic        ovf_reg, ovf_next;
  logic [32:0] partial;
  logic        fits;
  logic [31:0] a_mag, b_mag;

  // 33-bit partial remainder for this iteration and whether the divisor fits
  assign partial = {rem_reg, quo_reg[31]};
  assign fits    = (partial >= {1'b0, opb_reg});
  assign a_mag   = (bus.is_sign && bus.a[31]) ? (~bus.a + 32'd1) : bus.a;
  assign b_mag   = (bus.is_sign && bus.b[31]) ? (~bus.b + 32'd1) : bus.b;
`endif

  // Sign- or zero-extend to 64 bits so one unsigned multiply serves both cases
  assign mul_ext_a = {{32{sign_reg & opa_reg[31]}}, opa_reg};
  assign mul_ext_b = {{32{sign_reg & opb_reg[31]}}, opb_reg};
  assign product   = mul_ext_a * mul_ext_b;

  assign bus.hi    = hi_reg;
  assign bus.lo    = lo_reg;
  assign bus.busy  = (state_reg != IDLE);
  assign bus.stall = (state_reg != IDLE) & (bus.req_valid | bus.mf_req);

  // Next-state and datapath update; flush always returns to IDLE without writing HI/LO
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    opa_next   = opa_reg;
    opb_next   = opb_reg;
    sign_next  = sign_reg;
`ifdef MDU_DIV_EN
    quo_next   = quo_reg;
    rem_next   = rem_reg;
    qneg_next  = qneg_reg;
    rneg_next  = rneg_reg;
    dzero_next = dzero_reg;
    ovf_next   = ovf_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (bus.req_valid && !bus.flush) begin
          case (bus.func)
            F_MULT: begin
              opa_next   = bus.a;
              opb_next   = bus.b;
              sign_next  = bus.is_sign;
              cnt_next   = 5'(MUL_LAT - 1);
              state_next = MUL;
            end
            F_DIV: begin
`ifdef MDU_DIV_EN
              opa_next   = bus.a;
              opb_next   = b_mag;
              quo_next   = a_mag;
              rem_next   = '0;
              qneg_next  = bus.is_sign & (bus.a[31] ^ bus.b[31]);
              rneg_next  = bus.is_sign & bus.a[31];
              dzero_next = (bus.b == 32'd0);
              ovf_next   = bus.is_sign && (bus.a == 32'h8000_0000) && (bus.b == 32'hFFFF_FFFF);
              cnt_next   = 5'd31;
              state_next = DIV;
`endif
              // without the divider a DIV retires as a no-op
            end
            F_MTHI:  hi_next = bus.a;
            F_MTLO:  lo_next = bus.a;
            default: ;
          endcase
        end
      end
      MUL: begin
        if (bus.flush) begin
          state_next = IDLE;
        end else if (cnt_reg == 5'd0) begin
          hi_next    = product[63:32];
          lo_next    = product[31:0];
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - 5'd1;
        end
      end
`ifdef MDU_DIV_EN
      DIV: begin
        if (bus.flush) begin
          state_next = IDLE;
        end else begin
          rem_next = fits ? 32'(partial - {1'b0, opb_reg}) : partial[31:0];
          quo_next = {quo_reg[30:0], fits};
          if (cnt_reg == 5'd0) state_next = FIX;
          else                 cnt_next   = cnt_reg - 5'd1;
        end
      end
      FIX: begin
        state_next = IDLE;
        if (!bus.flush) begin
          if (dzero_reg) begin
            lo_next = 32'hFFFF_FFFF;
            hi_next = opa_reg;
          end else if (ovf_reg) begin
            lo_next = 32'h8000_0000;
            hi_next = 32'd0;
          end else begin
            lo_next = qneg_reg ? (~quo_reg + 32'd1) : quo_reg;
            hi_next = rneg_reg ? (~rem_reg + 32'd1) : rem_reg;
          end
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      opa_reg   <= '0;
      opb_reg   <= '0;
      sign_reg  <= 1'b0;
`ifdef MDU_DIV_EN
      quo_reg   <= '0;
      rem_reg   <= '0;
      qneg_reg  <= 1'b0;
      rneg_reg  <= 1'b0;
      dzero_reg <= 1'b0;
      ovf_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      opa_reg   <= opa_next;
      opb_reg   <= opb_next;
      sign_reg  <= sign_next;
`ifdef MDU_DIV_EN
      quo_reg   <= quo_next;
      rem_reg   <= rem_next;
      qneg_reg  <= qneg_next;
      rneg_reg  <= rneg_next;
      dzero_reg <= dzero_next;
      ovf_reg   <= ovf_next;
`endif
    end
  end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide sequencer for the EX stage. It accepts MULT/DIV/MTHI/MTLO operations from the instruction in EX, runs multi-cycle multiplies and iterative divides, and owns the architectural HI/LO registers. While an operation is in flight and the EX instruction needs the unit or HI/LO, it raises a stall request to the stall-detect logic. It sits beside the ALU, fed with forwarded operands, and its HI/LO outputs feed the EX result mux.

## Interface

- Clock and reset: one clock, `clk`; `rst` is synchronous and active-high.

Parameters:

- `MUL_LAT`, default 3: cycles from multiply acceptance to HI/LO update. Legal range is 1..8.

Ports:

- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous active-high reset
- `req_valid`  in  1  EX instruction is an MD operation
- `func`  in  3  operation code: 0=NONE, 1=MULT, 2=DIV, 3=MTHI, 4=MTLO, 5..7 treated as NONE
- `is_sign`  in  1  signed operation (MULT/DIV only)
- `a`  in  32  forwarded rs operand
- `b`  in  32  forwarded rt operand
- `mf_req`  in  1  EX instruction reads HI or LO (MFHI/MFLO)
- `flush`  in  1  EX flush; aborts any in-flight operation
- `hi`  out  32  architectural HI
- `lo`  out  32  architectural LO
- `busy`  out  1  registered; high while state ≠ IDLE
- `stall`  out  1  combinational: `busy & (req_valid | mf_req)`

## Operation

- States are IDLE, MUL, DIV and FIX.
- Acceptance happens only in IDLE with `req_valid=1`, `flush=0` and no `rst`.
  - MTHI writes `hi<=a`; MTLO writes `lo<=a`. Both take one cycle and leave the state at IDLE.
  - MULT latches the operands and `is_sign`, loads a counter with `MUL_LAT-1`, and moves to MUL.
  - DIV latches `|a|` and `|b|` (magnitudes when signed) plus the quotient/remainder signs, loads the counter with 31, and moves to DIV.
- MUL:
  - The 64-bit product (signed or unsigned) is formed from the latched operands.
  - The counter decrements each cycle.
  - At count 0, the unit writes `{hi,lo}<=product` and returns to IDLE.
- DIV:
  - One restoring shift-subtract iteration per cycle on a 33-bit partial remainder.
  - After the iteration at count 0, the unit moves to FIX.
- FIX (one cycle): apply sign correction, write `lo<=quotient` and `hi<=remainder`, then go to IDLE.
  - Quotient sign is `a[31]^b[31]`; remainder sign is `a[31]`.
  - Divide by zero, detected at acceptance: `lo<=32'hFFFFFFFF`, `hi<=a`.
  - Signed `32'h80000000 / 32'hFFFFFFFF`: `lo<=32'h80000000`, `hi<=0`.
  - The unsigned path passes through FIX unchanged, so latency is uniform.
- `req_valid` while busy:
  - Not accepted, and `stall=1`.
  - The pipeline holds EX; the request is accepted in the first IDLE cycle.
- `mf_req` while busy: `stall=1` until the cycle after HI/LO is written. In IDLE, `hi`/`lo` are current and `stall=0`.

## Timing

- Reset values: `hi=0`, `lo=0`, `busy=0`, `stall=0`, state=IDLE, counter=0.
- MULT accepted at edge E: `busy=1` for cycles E+1..E+`MUL_LAT`, and HI/LO are updated at edge E+`MUL_LAT`.
- DIV accepted at edge E: `busy=1` for 33 cycles (32 in DIV, 1 in FIX), and HI/LO are updated at edge E+33.
- `flush=1` at any edge:
  - Next state is IDLE and `busy=0`.
  - HI/LO keep their pre-operation values; a partial result is never written.
  - A request presented in the same cycle is ignored. Flush wins over acceptance.
- `rst` overrides `flush` and acceptance.
- `req_valid` and `mf_req` together are impossible (single EX instruction). If both occur, the request is handled and `mf_req` reads pre-request values.
- Back-to-back: a request arriving in the cycle `busy` falls is accepted at that edge.

## Configuration

- `MDU_DIV_EN` defined: the divider and the DIV/FIX states are built as described above.
- `MDU_DIV_EN` undefined:
  - DIV is accepted in one cycle as a no-op: HI/LO unchanged, `busy` stays 0.
  - No divider logic is synthesized. MULT/MTHI/MTLO are unaffected.

## Test plan

- Unsigned MULT, `a=32'hFFFFFFFF`, `b=2`, `MUL_LAT=3` -> `busy` high 3 cycles, then `hi=1`, `lo=32'hFFFFFFFE`. Signed MULT of -3 × 5 -> `hi=32'hFFFFFFFF`, `lo=32'hFFFFFFF1`.
- Signed DIV -7/2 -> `busy` high 33 cycles, then `lo=32'hFFFFFFFD`, `hi=32'hFFFFFFFF`. Unsigned 100/7 -> `lo=14`, `hi=2`.
- DIV 5/0 -> `lo=32'hFFFFFFFF`, `hi=5`. Signed `32'h80000000/32'hFFFFFFFF` -> `lo=32'h80000000`, `hi=0`.
- Preload `hi=32'hA`, `lo=32'hB` with MTHI/MTLO. Start DIV, assert `flush` 10 cycles in -> next cycle `busy=0`, `hi=32'hA`, `lo=32'hB`.
- `mf_req` held during a MULT -> `stall=1` exactly while `busy`; the first non-stalled cycle sees the new product. A MULT issued during a DIV is accepted on the cycle `busy` falls.
- With `MDU_DIV_EN` undefined, DIV 9/3 -> `busy` never asserts and HI/LO are unchanged.
